dispense_ctrl: RTL and testbench
================================

# dispense_ctrl

Parametrised drink-dispense sequencer for the coffee machine. It sits after the payment/selection FSM and generalises the fixed single-output dispense stage to NUM_DRINKS one-hot valve channels, adding a timed pour, a confirm timeout and a cup-removal abort. It takes the cup sensor, the confirm key, the upstream error flag and the drink index, and drives one valve for a fixed number of cycles.

## Interface
- NUM_DRINKS, 4, number of valve channels (1..2**SEL_W)
- SEL_W, 2, width of drink index
- CNT_W, 8, width of shared cycle counter
- POUR_CYCLES, 8, valve-open duration in cycles (1..2**CNT_W)
- TIMEOUT_CYCLES, 16, cycles allowed between cup detect and confirm (1..2**CNT_W)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- sensor  in  1  cup present (1 = cup on tray)
- enter  in  1  confirm key, sampled level
- erro  in  1  upstream payment/selection error
- sel  in  SEL_W  requested drink index
- bebidas  out  NUM_DRINKS  one-hot valve enables
- busy  out  1  high in CUP and POUR
- done  out  1  one-cycle pulse on pour completion
- err_out  out  1  high in FAULT
- state  out  3  current state code (debug)

## Operation
- States: IDLE=0, CUP=1, POUR=2, DONE=3, REMOVE=4, FAULT=5. Codes 6–7 return to IDLE on the next edge.
- All outputs are Moore decodes of the state register and the latched index (sel_q). There is no combinational input-to-output path.
- IDLE: sensor=1 → CUP, and the counter loads TIMEOUT_CYCLES-1.
- CUP transitions, highest priority first:
  - sensor=0 → IDLE.
  - enter=1 with erro=1 or sel>=NUM_DRINKS → FAULT.
  - enter=1 otherwise → POUR. sel_q latches sel and the counter loads POUR_CYCLES-1.
  - counter==0 → REMOVE (timeout).
  - else the counter decrements.
- POUR: bebidas = 1<<sel_q.
  - sensor=0 → FAULT (abort). Takes priority over completion.
  - counter==0 → DONE.
  - else the counter decrements.
  - enter and sel are ignored.
- DONE: done=1 for one cycle, then unconditionally → REMOVE.
- REMOVE: waits for sensor=0 → IDLE. This stops an uncleared cup from re-arming.
- FAULT: waits for sensor=0 and erro=0 in the same cycle → IDLE.
- sel_q changes only on the CUP→POUR transition.
- The counter is an unsigned CNT_W-bit down-counter and never wraps. It holds at 0 when its state exits.
- bebidas is all-zero in every state except POUR. At most one bit is ever high.

## Timing
- Reset values: state=IDLE, bebidas=0, busy=0, done=0, err_out=0, sel_q=0, counter=0.
- Reset asserted mid-POUR: the valve closes at the first clock edge with reset=1.
- A condition sampled at edge t takes effect in the state and outputs from edge t onward.
- Pour length: bebidas is high for exactly POUR_CYCLES consecutive cycles. done rises on the edge after the last valve cycle.
- Confirm window: enter is accepted on any of the TIMEOUT_CYCLES edges after CUP entry. The edge following the last accepted one moves to REMOVE.
- A single-cycle sensor drop in CUP or POUR is honoured; there is no debounce in this block.
- enter held high across DONE/REMOVE/IDLE does not start a second pour. A new pour requires a fresh cup detect and a CUP visit.

## Test plan
- Normal pour, defaults: sensor=1, then enter=1 with sel=2 on the 3rd CUP cycle → bebidas=4'b0100 for exactly 8 cycles, done pulse for 1 cycle, state=REMOVE until sensor=0, then IDLE.
- Invalid index: NUM_DRINKS=3, sel=3, enter=1 → FAULT and err_out=1; bebidas stays 0. Clearing sensor alone keeps FAULT; sensor=0 with erro=0 → IDLE.
- Upstream error: erro=1 during CUP with enter=1 → FAULT. erro=1 while in POUR has no effect and the pour completes its 8 cycles.
- Cup removed mid-pour: sensor drops on the 4th POUR cycle → bebidas=0 from that edge, FAULT, no done pulse.
- Timeout: sensor=1, enter never asserted → exactly 16 CUP cycles, then REMOVE; holding sensor=1 keeps REMOVE indefinitely.
- Reset mid-pour, plus simultaneous events: reset=1 on POUR cycle 5 → all outputs 0 on that edge. Separately, in CUP with sensor=0 and enter=1 in the same cycle → IDLE, no pour.

Source files
------------

// File: rtl/dispense_ctrl.sv
// ---------------------------------------------------------------------------
// dispense_ctrl
// Drink-dispense sequencer. After a cup is detected it waits a bounded time
// for the confirm key, then opens one of NUM_DRINKS valves for a fixed number
// of cycles. Removing the cup mid-pour aborts to FAULT. An upstream error or
// an out-of-range index at confirm time also goes to FAULT.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   sensor   in   cup present (1 = cup on tray)
//   enter    in   confirm key (level)
//   erro     in   upstream payment/selection error
//   sel      in   requested drink index [SEL_W]
//   bebidas  out  one-hot valve enables [NUM_DRINKS]
//   busy     out  high in CUP and POUR
//   done     out  one-cycle pulse when the pour completes
//   err_out  out  high in FAULT
//   state    out  current state code (debug)
//
// All outputs are Moore decodes of the state register and the latched index.
// ---------------------------------------------------------------------------
module dispense_ctrl #(
   parameter int NUM_DRINKS     = 4,
   parameter int SEL_W          = 2,
   parameter int CNT_W          = 8,
   parameter int POUR_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sensor,
   input  logic                  enter,
   input  logic                  erro,
   input  logic [SEL_W-1:0]      sel,
   output logic [NUM_DRINKS-1:0] bebidas,
   output logic                  busy,
   output logic                  done,
   output logic                  err_out,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CUP    = 3'd1,
      ST_POUR   = 3'd2,
      ST_DONE   = 3'd3,
      ST_REMOVE = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] POUR_LOAD    = CNT_W'(POUR_CYCLES - 1);

   state_t           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             sel_bad;

   // Index is checked against the number of fitted valves, which may be
   // fewer than the index width can express.
   assign sel_bad = (32'(sel) >= NUM_DRINKS);

   // State, counter and latched index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q  <= ST_IDLE;
         cnt_q <= '0;
         sel_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

   // Next-state logic. The counter only ever holds a value while CUP or POUR
   // is using it; every other path parks it at zero so it cannot wrap.
   always_comb begin
      st_d  = st_q;
      cnt_d = '0;
      sel_d = sel_q;
      case (st_q)
         ST_IDLE: begin
            if (sensor) begin
               st_d  = ST_CUP;
               cnt_d = TIMEOUT_LOAD;
            end
         end
         ST_CUP: begin
            if (!sensor) begin
               st_d = ST_IDLE;
            end else if (enter && (erro || sel_bad)) begin
               st_d = ST_FAULT;
            end else if (enter) begin
               st_d  = ST_POUR;
               sel_d = sel;
               cnt_d = POUR_LOAD;
            end else if (cnt_q == '0) begin
               st_d = ST_REMOVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_POUR: begin
            // Cup removal beats completion: never finish into an empty tray.
            if (!sensor) begin
               st_d = ST_FAULT;
            end else if (cnt_q == '0) begin
               st_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            st_d = ST_REMOVE;
         end
         ST_REMOVE: begin
            // Cup must leave before another one can arm the sequence.
            if (!sensor) st_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (!sensor && !erro) st_d = ST_IDLE;
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   // Moore output decode.
   always_comb begin
      bebidas = '0;
      if (st_q == ST_POUR) begin
         for (int i = 0; i < NUM_DRINKS; i++) begin
            bebidas[i] = (sel_q == SEL_W'(i));
         end
      end
   end

   assign busy    = (st_q == ST_CUP) || (st_q == ST_POUR);
   assign done    = (st_q == ST_DONE);
   assign err_out = (st_q == ST_FAULT);
   assign state   = st_q;

endmodule

// File: tb/tb_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dispense_ctrl
// Two instances share one set of inputs: a 4-valve unit and a 3-valve unit
// (so index 3 is out of range on the second). A phase/elapsed-time reference
// model predicts every output after every clock edge; directed scenarios add
// checks on pour length, done pulses and timeout length.
// ---------------------------------------------------------------------------
module tb_dispense_ctrl;

   localparam int POUR    = 8;
   localparam int TIMEOUT = 16;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, sensor, enter, erro;
   logic [1:0] sel;

   logic [3:0] beb_a;
   logic [2:0] beb_b;
   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [2:0] state_a, state_b;

   dispense_ctrl #(.NUM_DRINKS(4), .SEL_W(2), .CNT_W(8),
                   .POUR_CYCLES(POUR), .TIMEOUT_CYCLES(TIMEOUT)) dut_a (
      .clk(clk), .reset(reset), .sensor(sensor), .enter(enter), .erro(erro),
      .sel(sel), .bebidas(beb_a), .busy(busy_a), .done(done_a),
      .err_out(err_a), .state(state_a));

   dispense_ctrl #(.NUM_DRINKS(3), .SEL_W(2), .CNT_W(8),
                   .POUR_CYCLES(POUR), .TIMEOUT_CYCLES(TIMEOUT)) dut_b (
      .clk(clk), .reset(reset), .sensor(sensor), .enter(enter), .erro(erro),
      .sel(sel), .bebidas(beb_b), .busy(busy_b), .done(done_b),
      .err_out(err_b), .state(state_b));

   // scoreboard counters
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: phase plus cycles elapsed inside that phase
   typedef enum int {P_IDLE = 0, P_CUP = 1, P_POUR = 2, P_DONE = 3,
                     P_REMOVE = 4, P_FAULT = 5} phase_t;
   phase_t ph [2];
   int     elapsed [2];
   int     msel [2];
   int     nd [2] = '{4, 3};

   task automatic model_step(input int k);
      if (reset) begin
         ph[k] = P_IDLE; elapsed[k] = 0; msel[k] = 0;
         return;
      end
      case (ph[k])
         P_IDLE: if (sensor) begin ph[k] = P_CUP; elapsed[k] = 0; end
         P_CUP: begin
            if (!sensor) ph[k] = P_IDLE;
            else if (enter && (erro || int'(sel) >= nd[k])) ph[k] = P_FAULT;
            else if (enter) begin
               ph[k] = P_POUR; msel[k] = int'(sel); elapsed[k] = 0;
            end
            else if (elapsed[k] == TIMEOUT - 1) ph[k] = P_REMOVE;
            else elapsed[k]++;
         end
         P_POUR: begin
            if (!sensor) ph[k] = P_FAULT;
            else if (elapsed[k] == POUR - 1) ph[k] = P_DONE;
            else elapsed[k]++;
         end
         P_DONE:   ph[k] = P_REMOVE;
         P_REMOVE: if (!sensor) ph[k] = P_IDLE;
         P_FAULT:  if (!sensor && !erro) ph[k] = P_IDLE;
         default:  ph[k] = P_IDLE;
      endcase
   endtask

   // per-scenario observers on instance A
   int valve_cycles, done_pulses, cup_cycles;

   task automatic compare_all();
      logic [31:0] eb [2];
      for (int k = 0; k < 2; k++)
         eb[k] = (ph[k] == P_POUR) ? (32'd1 << msel[k]) : 32'd0;
      check("a_state", 32'(state_a), 32'(int'(ph[0])));
      check("a_bebidas", 32'(beb_a), eb[0]);
      check("a_busy", 32'(busy_a), 32'(ph[0] == P_CUP || ph[0] == P_POUR));
      check("a_done", 32'(done_a), 32'(ph[0] == P_DONE));
      check("a_err", 32'(err_a), 32'(ph[0] == P_FAULT));
      check("b_state", 32'(state_b), 32'(int'(ph[1])));
      check("b_bebidas", 32'(beb_b), eb[1]);
      check("b_busy", 32'(busy_b), 32'(ph[1] == P_CUP || ph[1] == P_POUR));
      check("b_done", 32'(done_b), 32'(ph[1] == P_DONE));
      check("b_err", 32'(err_b), 32'(ph[1] == P_FAULT));
   endtask

   // driver: one clock edge, model update, output compare
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all();
      if (beb_a != 0) valve_cycles++;
      if (done_a) done_pulses++;
      if (state_a == 3'd1) cup_cycles++;
   endtask

   task automatic clear_obs();
      valve_cycles = 0; done_pulses = 0; cup_cycles = 0;
   endtask

   initial begin
      reset = 1'b1; sensor = 1'b0; enter = 1'b0; erro = 1'b0; sel = 2'd0;
      ph = '{P_IDLE, P_IDLE}; elapsed = '{0, 0}; msel = '{0, 0};
      clear_obs();
      tick();
      tick();
      reset = 1'b0;
      check("reset_state", 32'(state_a), 32'd0);
      check("reset_bebidas", 32'(beb_a), 32'd0);

      // normal pour, confirm on the 3rd CUP cycle
      sensor = 1'b1; tick();
      tick(); tick();
      clear_obs();
      enter = 1'b1; sel = 2'd2; tick();
      check("pour_first_valve", 32'(beb_a), 32'h4);
      enter = 1'b0;
      repeat (11) tick();
      check("pour_len", 32'(valve_cycles), 32'(POUR));
      check("pour_done_pulses", 32'(done_pulses), 32'd1);
      check("pour_remove_hold", 32'(state_a), 32'd4);
      sensor = 1'b0; tick();
      check("pour_back_idle", 32'(state_a), 32'd0);

      // invalid index on the 3-valve unit; clearing sensor alone keeps FAULT
      sensor = 1'b1; tick();
      enter = 1'b1; sel = 2'd3; tick();
      enter = 1'b0;
      check("inv_err", 32'(err_b), 32'd1);
      check("inv_valve", 32'(beb_b), 32'd0);
      sensor = 1'b0; erro = 1'b1; tick();
      check("inv_fault_hold", 32'(state_b), 32'd5);
      erro = 1'b0; tick();
      check("inv_clear", 32'(state_b), 32'd0);

      // upstream error at confirm, then erro ignored during pour
      sensor = 1'b1; tick();
      erro = 1'b1; enter = 1'b1; sel = 2'd1; tick();
      check("erro_fault", 32'(state_a), 32'd5);
      enter = 1'b0; sensor = 1'b0; erro = 1'b0; tick();
      sensor = 1'b1; tick();
      clear_obs();
      enter = 1'b1; tick();
      enter = 1'b0; erro = 1'b1;
      repeat (9) tick();
      check("erro_pour_len", 32'(valve_cycles), 32'(POUR));
      check("erro_pour_done", 32'(done_pulses), 32'd1);
      erro = 1'b0; sensor = 1'b0; tick();

      // cup removed on the 4th pour cycle
      sensor = 1'b1; tick();
      clear_obs();
      enter = 1'b1; sel = 2'd0; tick();
      enter = 1'b0; tick(); tick();
      sensor = 1'b0; tick();
      check("abort_valve", 32'(beb_a), 32'd0);
      check("abort_fault", 32'(state_a), 32'd5);
      repeat (3) tick();
      check("abort_valve_cycles", 32'(valve_cycles), 32'd3);
      check("abort_no_done", 32'(done_pulses), 32'd0);

      // timeout: exactly TIMEOUT cycles in CUP, REMOVE held while cup stays
      clear_obs();
      sensor = 1'b1; tick();
      repeat (40) tick();
      check("timeout_cup_cycles", 32'(cup_cycles), 32'(TIMEOUT));
      check("timeout_remove", 32'(state_a), 32'd4);
      sensor = 1'b0; tick();

      // reset on the 5th pour cycle
      sensor = 1'b1; tick();
      enter = 1'b1; sel = 2'd3; tick();
      enter = 1'b0; repeat (3) tick();
      reset = 1'b1; tick();
      check("rst_valve", 32'(beb_a), 32'd0);
      check("rst_state", 32'(state_a), 32'd0);
      reset = 1'b0; sensor = 1'b0; tick();

      // sensor drop and enter in the same CUP cycle
      clear_obs();
      sensor = 1'b1; tick();
      sensor = 1'b0; enter = 1'b1; tick();
      enter = 1'b0;
      check("simul_idle", 32'(state_a), 32'd0);
      tick();
      check("simul_no_pour", 32'(valve_cycles), 32'd0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 7) == 0) sensor = ~sensor;
         enter = ($urandom_range(0, 5) == 0);
         erro  = ($urandom_range(0, 9) == 0);
         sel   = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      checks++;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
